// File: rtl/isa_core.sv
// isa_core: single-cycle 20-bit ISA execute core with 16x32 register file; `define ISA_FLAGS_EN adds the {N,Z,C,V} flags port
module isa_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] Instruction,
`ifdef ISA_FLAGS_EN
  output logic [3:0]  flags,
`endif
  output logic [31:0] Salida
);
  logic [31:0] r_regs [16];
  logic [3:0]  w_op, w_rd, w_rs1, w_rs2;
  logic [31:0] w_a, w_b, w_addb, w_sum, w_res;
  logic        w_cin, w_wr, w_upd;
  assign w_op   = Instruction[19:16];
  assign w_rd   = Instruction[15:12];
  assign w_rs1  = Instruction[11:8];
  assign w_rs2  = Instruction[7:4];
  assign w_a    = r_regs[w_rs1];
  assign w_b    = r_regs[w_rs2];
  assign w_cin  = w_op == 4'h2;
  assign w_addb = w_op == 4'h2 ? ~w_b : w_op == 4'hA ? {{24{Instruction[7]}}, Instruction[7:0]} : w_b;
  assign w_sum  = w_a + w_addb + {31'b0, w_cin};
  assign w_upd  = w_op != 4'h0;
  assign w_wr   = w_upd && w_op != 4'hF && w_rd != 4'h0;
  always_comb begin
    w_res = w_sum;
    case (w_op)
      4'h3: w_res = w_a & w_b;
      4'h4: w_res = w_a | w_b;
      4'h5: w_res = w_a ^ w_b;
      4'h6: w_res = w_a << w_b[4:0];
      4'h7: w_res = w_a >> w_b[4:0];
      4'h8: w_res = $signed(w_a) >>> w_b[4:0];
      4'h9: w_res = {31'b0, $signed(w_a) < $signed(w_b)};
      4'hB: w_res = {Instruction[11:0], 20'h0};
      4'hC: w_res = {20'h0, Instruction[11:0]};
      4'hD: w_res = w_a * w_b;
      4'hE: w_res = w_a;
      4'hF: w_res = w_a;
      default: w_res = w_sum;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= 32'h0;
      Salida <= 32'h0;
    end else begin
      if (w_wr) r_regs[w_rd] <= w_res;
      if (w_upd) Salida <= w_res;
    end
  end
`ifdef ISA_FLAGS_EN
  logic w_arith, w_c, w_v;
  assign w_arith = w_op == 4'h1 || w_op == 4'h2 || w_op == 4'hA;
  assign w_c = w_arith && ((w_a[31] & w_addb[31]) | ((w_a[31] ^ w_addb[31]) & ~w_sum[31]));
  assign w_v = w_arith && (w_a[31] == w_addb[31]) && (w_sum[31] != w_a[31]);
  always_ff @(posedge clk) begin
    if (rst) flags <= 4'h0;
    else if (w_upd && w_op <= 4'hD) flags <= {w_res[31], w_res == 32'h0, w_c, w_v};
  end
`endif
endmodule

// File: tb/tb_isa_core.sv
// tb_isa_core: directed scoreboard bench for isa_core
module tb_isa_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] Instruction = 20'h0;
  logic [31:0] Salida;
`ifdef ISA_FLAGS_EN
  logic [3:0]  flags;
`endif
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  always #5 clk = ~clk;
  isa_core dut (
    .clk(clk),
    .rst(rst),
    .Instruction(Instruction),
`ifdef ISA_FLAGS_EN
    .flags(flags),
`endif
    .Salida(Salida)
  );
  task automatic check(input string tag);
    logic [31:0] e;
    e = sb.pop_front();
    checks++;
    assert (Salida === e) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, Salida, e);
    end
  endtask
  task automatic step(input logic [19:0] ins, input logic [31:0] exp, input string tag);
    @(negedge clk);
    Instruction = ins;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check(tag);
  endtask
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    Instruction = 20'hC1FFF;
    repeat (cycles) @(posedge clk);
    #1;
    sb.push_back(32'h0);
    check("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    do_reset(2);
    step(20'hF0500, 32'h00000000, "out_r5_after_reset");
    step(20'hC1005, 32'h00000005, "ldi_r1");
    step(20'hC2007, 32'h00000007, "ldi_r2");
    step(20'h13120, 32'h0000000C, "add");
    step(20'h24120, 32'hFFFFFFFE, "sub");
    step(20'h95410, 32'h00000001, "slt_true");
    step(20'h86410, 32'hFFFFFFFF, "sra");
    step(20'h77410, 32'h07FFFFFF, "srl");
    step(20'hC0ABC, 32'h00000ABC, "ldi_r0");
    step(20'hF0000, 32'h00000000, "out_r0");
    step(20'hB8FFF, 32'hFFF00000, "lui");
    step(20'hA98FF, 32'hFFEFFFFF, "addi_neg");
    step(20'h00000, 32'hFFEFFFFF, "nop_hold");
    step(20'h3A320, 32'h00000004, "and");
    step(20'h4A320, 32'h0000000F, "or");
    step(20'h5B320, 32'h0000000B, "xor");
    step(20'h6C120, 32'h00000280, "sll");
    step(20'hDD420, 32'hFFFFFFF2, "mul");
    step(20'hEED00, 32'hFFFFFFF2, "mov");
    step(20'h9F140, 32'h00000000, "slt_false");
    step(20'h11020, 32'h00000007, "add_r0_src");
    step(20'hF0C00, 32'h00000280, "out_r12");
    step(20'h8F890, 32'hFFFFFFFF, "sra_31");
    step(20'hF0100, 32'h00000007, "out_r1");
    step(20'h00000, 32'h00000007, "nop_hold2");
    do_reset(1);
    step(20'hF0300, 32'h00000000, "out_r3_cleared");
    step(20'hF0E00, 32'h00000000, "out_r14_cleared");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/isa_core.md
Name: isa_core

Overview:
- Single-issue, single-cycle execute block for a 20-bit custom ISA.
- Each clock, one instruction is decoded, operands are read from an internal 16x32 register file, and the ALU executes.
- The result is written back and presented on Salida.
- Sits between the instruction memory/sequencer, which feeds one instruction per cycle, and downstream display/debug logic.

Parameters:
- NREGS, 16, number of general registers (fixed at 16: 4-bit register fields).
- XLEN, 32, datapath and Salida width.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- Instruction  input  20  instruction word, sampled every rising clk edge.
- Salida  output  32  registered result of the last executed instruction.

Behaviour:
- Reset: one clock; rst is synchronous and active-high.
  - When rst=1 at a rising edge, all 16 registers become 0 and Salida becomes 32'h0.
  - Instruction is ignored during that cycle.
- Encoding fields:
  - op=[19:16], rd=[15:12], rs1=[11:8], rs2=[7:4], imm8=[7:0], imm12=[11:0].
- Latency: 1 cycle.
  - Operands are read combinationally.
  - At the rising edge, the result is written to R[rd] and to Salida simultaneously.
- Read-after-write: an instruction at edge N+1 sees the value written at edge N.
  - No internal bypass is needed because the register file is written at the edge.
- R0 always reads 0 and writes to it are discarded. Salida still shows the computed result.
- Opcodes (all arithmetic is modulo 2^32, two's complement, no traps):
  - 0 NOP: no write; Salida holds its previous value.
  - 1 ADD: rs1+rs2.
  - 2 SUB: rs1-rs2.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLL: rs1 << rs2[4:0].
  - 7 SRL: logical right shift by rs2[4:0].
  - 8 SRA: arithmetic right shift by rs2[4:0].
  - 9 SLT: signed rs1<rs2 gives 1, else 0.
  - A ADDI: rs1 + signext(imm8).
  - B LUI: {imm12, 20'h0}.
  - C LDI: zeroext(imm12).
  - D MUL: low 32 bits of rs1*rs2.
  - E MOV: rs1.
  - F OUT: Salida=R[rs1]; no register write.
- Here rs1/rs2 denote R[rs1]/R[rs2].
- Shift amounts ≥32 cannot occur, because only 5 bits of rs2 are used.
- X/Z on Instruction is not defined. A bench must drive known values after reset.

Optional Feature:
- Macro ISA_FLAGS_EN.
- When defined, adds output port flags (4 bits, {N,Z,C,V}).
  - Registered and updated on every ALU instruction (ops 1-D).
  - Held on NOP, MOV and OUT; reset to 0.
  - N = result[31]; Z = (result==0).
  - C = carry-out for ADD/ADDI and NOT borrow for SUB, else 0.
  - V = signed overflow for ADD/ADDI/SUB, else 0.
- When not defined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles, then release and apply OUT R5 (20'hF0500) -> Salida=32'h00000000.
- LDI R1,5 (20'hC1005) -> Salida=32'h00000005. Then LDI R2,7 (20'hC2007) -> Salida=32'h00000007.
- ADD R3,R1,R2 (20'h13120) -> Salida=32'h0000000C. Then SUB R4,R1,R2 (20'h24120) -> Salida=32'hFFFFFFFE.
- SLT R5,R4,R1 (20'h95410) -> 32'h00000001. SRA R6,R4,R1 (20'h86410) -> 32'hFFFFFFFF. SRL R7,R4,R1 (20'h77410) -> 32'h07FFFFFF.
- R0 rule: LDI R0,0xABC (20'hC0ABC) -> Salida=32'h00000ABC. Then OUT R0 (20'hF0000) -> Salida=32'h00000000.
- LUI R8,0xFFF (20'hB8FFF) -> 32'hFFF00000. ADDI R9,R8,-1 (20'hA98FF) -> 32'hFFEFFFFF. NOP (20'h00000) -> Salida unchanged.
